// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, scan-result types and key lookup
// for the 4x3 matrix keypad scan controller.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [3:0] ROW_PAT [4] = '{
    4'b1101, 4'b1011, 4'b0111, 4'b1110
  };

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } scan_res_e;

  typedef struct packed {
    scan_res_e  kind;
    logic [3:0] code;
  } scan_t;

  localparam scan_t SCAN_NONE = '{kind: RES_NONE, code: 4'd0};

  // Row index and column index (0 = left) to key code.
  function automatic logic [3:0] key_lookup(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = 4'd3 * {2'b00, r} + {2'b00, c} + 4'd1;
    if (r == 2'd3) begin
      case (c)
        2'd0:    k = KEY_STAR;
        2'd1:    k = 4'd0;
        default: k = KEY_HASH;
      endcase
    end
    return k;
  endfunction

  // Position of the (single) low bit of an active-low column word.
  function automatic logic [1:0] col_index(input logic [2:0] col_n);
    logic [1:0] c;
    c = 2'd2;
    if (!col_n[1]) c = 2'd1;
    if (!col_n[0]) c = 2'd0;
    return c;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: valid/ready key-code stream from the
// scan controller (master) to its consumer (slave).
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/keypad_fifo.sv
// keypad_fifo: small synchronous FIFO of 4-bit key codes;
// head reads 0 while empty, simultaneous push+pop allowed when full.
module keypad_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [3:0]             din_i,
  input  logic                   pop_i,
  output logic [3:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = empty_o ? 4'd0 : mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x3 keypad row scanner, whole-scan debounce and
// key-event FIFO. Define KEYPAD_REPEAT_EN to enable auto-repeat.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  colum,
  output logic [3:0]                  row,
  keypad_scan_ctrl_if.master          key_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       hit_q, hit_d;
  logic [3:0]       code_q, code_d;
  scan_t            cand_q, cand_d;
  scan_t            acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q;

  logic       scan_done;
  scan_t      res;
  logic [1:0] nz, hit_new;
  logic [2:0] hit_sum;
  logic [3:0] code_new;
  logic       evt_push, push, pop;
  logic       fifo_full, fifo_empty;

  assign row = ROW_PAT[slot_q];

  // Slot timing and per-scan accumulation of closed contacts.
  always_comb begin
    div_d     = div_q + DIV_W'(1);
    slot_d    = slot_q;
    hit_d     = hit_q;
    code_d    = code_q;
    scan_done = 1'b0;
    res       = SCAN_NONE;
    nz        = 2'(!colum[0]) + 2'(!colum[1]) + 2'(!colum[2]);
    hit_sum   = 3'(hit_q) + 3'(nz);
    hit_new   = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    code_new  = code_q;
    if (nz == 2'd1 && hit_q == 2'd0)
      code_new = key_lookup(slot_q, col_index(colum));
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      slot_d = slot_q + 2'd1;
      if (slot_q == 2'd3) begin
        scan_done = 1'b1;
        hit_d     = 2'd0;
        code_d    = 4'd0;
        if (hit_new == 2'd2) res.kind = RES_MULTI;
        if (hit_new == 2'd1) res = '{kind: RES_KEY, code: code_new};
        if (res.kind == RES_MULTI) res = SCAN_NONE;
      end else begin
        hit_d  = hit_new;
        code_d = code_new;
      end
    end
  end

  // Debounce: a result must repeat DEBOUNCE_SCANS times to be accepted.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (scan_done) begin
      if (res == cand_q) begin
        if (cnt_q != DEB_N) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = res;
        cnt_d  = 4'd1;
      end
      if (cnt_d == DEB_N) acc_d = cand_d;
    end
  end

  assign evt_push = scan_done && (acc_d != acc_q) &&
                    (acc_d.kind == RES_KEY);

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_DLY  = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_RATE = 16'(REPEAT_RATE);

  logic [15:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic        rep_first_q, rep_first_d, rep_push;

  // Auto-repeat: count full scans while the accepted key is held.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_push    = 1'b0;
    rep_next    = rep_cnt_q + 16'd1;
    if (scan_done) begin
      if (acc_d != acc_q) begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end else if (acc_q.kind == RES_KEY) begin
        if (rep_next == (rep_first_q ? REP_DLY : REP_RATE)) begin
          rep_push    = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_next;
        end
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign push = evt_push || rep_push;
`else
  localparam int UNUSED_REPEAT = REPEAT_DELAY + REPEAT_RATE;

  assign push = evt_push;
`endif

  assign pop = key_if.key_ready && !fifo_empty;

  // Scan and debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      slot_q <= 2'd0;
      hit_q  <= 2'd0;
      code_q <= 4'd0;
      cand_q <= SCAN_NONE;
      acc_q  <= SCAN_NONE;
      cnt_q  <= 4'd0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
      hit_q  <= hit_d;
      code_q <= code_d;
      cand_q <= cand_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  // Sticky flag for a push dropped on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (push && fifo_full && !pop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;

  keypad_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (acc_d.code),
    .pop_i   (pop),
    .dout_o  (key_if.key_code),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign key_if.key_valid = !fifo_empty;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench with a keypad contact model,
// two DUTs (FIFO depth 4 and 2) sharing clock, reset and columns.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colum;
  logic [3:0] row1, row2;
  logic [2:0] cnt1;
  logic [1:0] cnt2;
  logic       ovf1, ovf2;
  logic [11:0] keys = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int q1[$], t1[$], q2[$], t2[$];

  keypad_scan_ctrl_if k1();
  keypad_scan_ctrl_if k2();

  keypad_scan_ctrl #(
    .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .colum(colum), .row(row1),
    .key_if(k1), .fifo_count(cnt1), .overflow(ovf1)
  );

  keypad_scan_ctrl #(
    .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(2),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .colum(colum), .row(row2),
    .key_if(k2), .fifo_count(cnt2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  function automatic int krow(input int k);
    if (k == 0 || k >= 10) return 3;
    return (k - 1) / 3;
  endfunction

  function automatic int kcol(input int k);
    if (k == 10) return 0;
    if (k == 0) return 1;
    if (k == 11) return 2;
    return (k - 1) % 3;
  endfunction

  // Keypad contacts: a pressed key pulls its column low while its row is driven.
  always_comb begin
    int ridx;
    colum = 3'b111;
    case (row1)
      4'b1101: ridx = 0;
      4'b1011: ridx = 1;
      4'b0111: ridx = 2;
      4'b1110: ridx = 3;
      default: ridx = 4;
    endcase
    for (int k = 0; k < 12; k++)
      if (keys[k] && krow(k) == ridx) colum[kcol(k)] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (k1.key_valid && k1.key_ready) begin
      q1.push_back(int'(k1.key_code));
      t1.push_back(cyc);
    end
    if (k2.key_valid && k2.key_ready) begin
      q2.push_back(int'(k2.key_code));
      t2.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_q();
    q1.delete(); t1.delete(); q2.delete(); t2.delete();
  endtask

  task automatic press(input int k, input int hold, input int gap);
    keys[k] = 1'b1;
    run(16 * hold);
    keys = '0;
    run(16 * gap);
  endtask

  logic [3:0] rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int exp3 [4] = '{1, 11, 0, 7};
`ifdef KEYPAD_REPEAT_EN
  localparam int NREP = 6;
  int exp_t [6] = '{32, 96, 128, 160, 192, 224};
`else
  localparam int NREP = 1;
  int exp_t [1] = '{32};
`endif

  initial begin
    k1.key_ready = 1'b0;
    k2.key_ready = 1'b0;

    @(negedge clk);
    check("rst_row", 32'(row1), 32'(4'b1101));
    check("rst_code", 32'(k1.key_code), 0);
    check("rst_valid", 32'(k1.key_valid), 0);
    check("rst_count", 32'(cnt1), 0);
    check("rst_ovf", 32'(ovf1), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    for (int p = 0; p < 32; p++) begin
      check("row_seq", 32'(row1), 32'(rows[(p / 4) % 4]));
      check("row_dut2", 32'(row2), 32'(rows[(p / 4) % 4]));
      tick();
    end
    check("idle_valid", 32'(k1.key_valid), 0);
    check("idle_ovf", 32'(ovf1), 0);

    k1.key_ready = 1'b1;
    k2.key_ready = 1'b1;
    press(5, 5, 4);
    check("k5_hs", q1.size(), 1);
    check("k5_code", (q1.size() > 0) ? q1[0] : -1, 5);
    check("k5_time", (t1.size() > 0) ? t1[0] : -1, 64);
    check("k5_hs2", q2.size(), 1);
    check("k5_cnt", 32'(cnt1), 0);
    clear_q();

    k1.key_ready = 1'b0;
    k2.key_ready = 1'b0;
    press(1, 3, 3);
    press(11, 3, 3);
    check("q_cnt_a", 32'(cnt1), 2);
    check("q_full2", 32'(cnt2), 2);
    keys[0] = 1'b1;
    run(31);
    k2.key_ready = 1'b1;
    tick();
    k2.key_ready = 1'b0;
    run(16);
    keys = '0;
    run(48);
    check("q_cnt_b", 32'(cnt1), 3);
    check("q_head", 32'(k1.key_code), 1);
    check("q_ovf", 32'(ovf1), 0);
    check("pp_cnt2", 32'(cnt2), 2);
    check("pp_ovf2", 32'(ovf2), 0);
    check("pp_head2", 32'(k2.key_code), 11);
    check("pp_pop2", (q2.size() == 1) ? q2[0] : -1, 1);

    press(7, 3, 3);
    check("of_cnt1", 32'(cnt1), 4);
    check("of_ovf1", 32'(ovf1), 0);
    check("of_cnt2", 32'(cnt2), 2);
    check("of_ovf2", 32'(ovf2), 1);
    check("of_head2", 32'(k2.key_code), 11);

    k1.key_ready = 1'b1;
    k2.key_ready = 1'b1;
    run(16);
    check("drain_n", q1.size(), 4);
    for (int i = 0; i < 4; i++)
      check("drain_code", (i < q1.size()) ? q1[i] : -1, exp3[i]);
    check("drain_valid", 32'(k1.key_valid), 0);
    check("drain_code0", 32'(k1.key_code), 0);
    check("drain2_n", q2.size(), 3);
    for (int i = 0; i < 3; i++)
      check("drain2_code", (i < q2.size()) ? q2[i] : -1, exp3[i]);
    check("drain2_cnt", 32'(cnt2), 0);
    clear_q();

    keys[3] = 1'b1;
    run(48);
    keys = '0;
    keys[6] = 1'b1;
    run(48);
    keys = '0;
    run(48);
    check("kk_n", q1.size(), 2);
    check("kk_a", (q1.size() > 0) ? q1[0] : -1, 3);
    check("kk_b", (q1.size() > 1) ? q1[1] : -1, 6);
    clear_q();

    keys[2] = 1'b1;
    keys[8] = 1'b1;
    run(96);
    keys = '0;
    run(48);
    check("multi_hs", q1.size(), 0);
    check("multi_cnt", 32'(cnt1), 0);
    check("multi_ovf", 32'(ovf1), 0);

    k1.key_ready = 1'b0;
    k2.key_ready = 1'b0;
    keys[9] = 1'b1;
    run(48);
    check("hold_cnt", 32'(cnt1), 1);
    check("hold_ovf2", 32'(ovf2), 1);
    run(5);
    check("pre_rst_row", 32'(row1), 32'(4'b1011));
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", 32'(row1), 32'(4'b1101));
    check("mid_rst_valid", 32'(k1.key_valid), 0);
    check("mid_rst_cnt", 32'(cnt1), 0);
    check("mid_rst_ovf2", 32'(ovf2), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    clear_q();
    k1.key_ready = 1'b1;
    k2.key_ready = 1'b1;
    check("rel_row", 32'(row1), 32'(4'b1101));
    run(224);
    keys = '0;
    run(64);
    check("rep_n", q1.size(), NREP);
    for (int i = 0; i < NREP; i++) begin
      check("rep_code", (i < q1.size()) ? q1[i] : -1, 9);
      check("rep_time", (i < t1.size()) ? t1[i] : -1, exp_t[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x3 matrix keypad. Drives the active-low rows, samples the active-low columns, debounces whole-matrix scans and turns each new key press into a 4-bit key code. Codes are queued in a small FIFO and handed to the consumer (display or application logic) over a valid/ready handshake. It replaces free-running, undebounced row scanning so that each key press is reported exactly once.

## Interface
- SCAN_DIV, 100000: clk cycles per row slot; legal range 2..2^20.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed before a result is accepted; legal range 1..15.
- FIFO_DEPTH, 4: key-event FIFO entries; must be a power of two, at least 2.
- REPEAT_DELAY, 32: full scans from acceptance to the first auto-repeat (used only with the repeat feature).
- REPEAT_RATE, 8: full scans between later auto-repeats (used only with the repeat feature).
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- colum  in  3  column sense, active-low; bit0 is the left column, bit2 the right column.
- row  out  4  row drive, active-low, exactly one bit low at any time.
- key_code  out  4  key code at the FIFO head.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts key_code this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- Row slots repeat in the cycle R0→R1→R2→R3→R0, with row = 1101, 1011, 0111, 1110.
- Keys in R0 are 1,2,3; R1 is 4,5,6; R2 is 7,8,9; R3 is *,0,#. Each group is listed left to right (colum 110, 101, 011).
- Key codes: digits map to their own value (0–9), * = 10, # = 11. Codes 12–15 are never produced.
- colum is sampled in the last cycle of each slot; the earlier cycles of the slot give the lines time to settle.
- The 4 slots together form one full scan. A scan result is NONE, KEY(k) or MULTI. MULTI means two or more closed contacts anywhere in the matrix, and is treated as NONE.
- Debounce holds a candidate and an accepted value, both reset to NONE.
  - A scan result equal to the candidate increments the match counter, which saturates at DEBOUNCE_SCANS.
  - A scan result that differs from the candidate becomes the new candidate, with the counter reset to 1.
  - When the counter reaches DEBOUNCE_SCANS, the accepted value is set to the candidate.
- Event rule: a change of the accepted value to KEY(k) pushes k. This covers NONE→KEY(k) and KEY(j)→KEY(k) with k≠j. Changes to NONE push nothing.
- FIFO:
  - Push happens on the cycle the accepted value updates.
  - Pop happens when key_valid && key_ready.
  - A push while the FIFO is full and no pop occurs in the same cycle is dropped, and overflow is set to 1. overflow clears only on reset.
  - A push and a pop in the same cycle while full both succeed; count is unchanged and overflow is not set.
  - A pop while empty has no effect.
- key_code is 0 whenever the FIFO is empty.

## Timing
- Reset values:
  - Outputs: row=1101, key_code=0, key_valid=0, fifo_count=0, overflow=0.
  - Internal: slot counter 0, debounce state NONE, FIFO pointers 0.
- Reset mid-operation immediately empties the FIFO, discards any partial scan and restarts at R0.
- A full scan takes 4*SCAN_DIV cycles. Minimum press-to-push time is DEBOUNCE_SCANS full scans, plus up to one extra scan for alignment.
- Push to key_valid: key_valid rises 1 cycle after a push into an empty FIFO. The pushed code is not visible in the cycle of the push.
- After a pop, the next entry appears on key_code in the following cycle. fifo_count updates in the cycle after each push or pop.
- row changes on the cycle after the sample cycle, with no gap between slots.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - While the accepted value stays KEY(k), k is pushed again after REPEAT_DELAY full scans, then every REPEAT_RATE full scans.
  - The repeat counter restarts on every change of the accepted value.
  - Repeat pushes follow the same overflow rules as normal pushes.
- KEYPAD_REPEAT_EN undefined: exactly one push per accepted press. The REPEAT_* parameters are ignored and the repeat logic is removed.

## Structure
- Package keypad_pkg holds:
  - key-code constants KEY_STAR=10 and KEY_HASH=11;
  - the row drive patterns ROW_PAT[0..3];
  - the scan-result enum (NONE, KEY, MULTI);
  - the row/column-to-code lookup function.
- Sub-module keypad_fifo: a synchronous FIFO (parameter DEPTH, 4-bit data) with push, pop, full, empty and count, reset by rst_n.
- The scan timing, debounce and event logic remain in keypad_scan_ctrl.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, giving 16-cycle scans.
- Reset release: row sequence is 1101,1011,0111,1110, 4 cycles each, repeating. key_valid stays 0 and overflow stays 0.
- Hold key 5 (colum=101 during R1) for 5 scans with key_ready=1. Exactly one handshake occurs, with key_code=5, about 2–3 scans after the press. There is no event on release.
- Press 1, release, press #, release, press 0, with key_ready=0 and FIFO_DEPTH=4. Result: fifo_count=3. Then raise key_ready: codes 1, 11, 0 are delivered in order and key_valid falls.
- Press keys 2 and 8 together for 6 scans. No push occurs and fifo_count stays 0.
- FIFO_DEPTH=2, key_ready=0, three separate presses. fifo_count=2, overflow=1, and the head code is the first key. A push coinciding with a pop while full leaves overflow unchanged.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=4 and REPEAT_RATE=2, hold 9 for 12 scans after acceptance. Pushes occur at acceptance and at +4, +6, +8, +10 and +12 scans (6 events). Asserting rst_n=0 mid-hold empties the FIFO and returns row to 1101 immediately.
